cordic_op_dispatcher: RTL

// - Upstream command stage for top_level_calc_cordic. Buffers CORDIC requests (op, x, y, z, tag) in a FIFO.
// - Issues each request to the calculator as a one-cycle enable pulse, then waits for done.
// - Returns the result, with tag and error flag, on a valid/ready output stream.
// - Lets a host stream operations back-to-back with no per-op handshake timing.

---
 rtl/cordic_op_dispatcher_pkg.sv | 48 ++++
 rtl/cordic_op_dispatcher_if.sv | 49 ++++
 rtl/cordic_op_dispatcher_fifo.sv | 62 ++++++
 rtl/cordic_op_dispatcher.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cordic_op_dispatcher_pkg.sv
// Shared types and constants for the CORDIC command dispatcher.
// Op codes and Q16.16 constants match the downstream calculator.
package cordic_op_dispatcher_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TIMEOUT   = 64;
    localparam int unsigned FRAC_BITS = 16;

    localparam logic [WIDTH-1:0] ONE = 32'h0001_0000;

    typedef enum logic [OP_W-1:0] {
        OP_SIN     = 4'd0,
        OP_COS     = 4'd1,
        OP_TAN     = 4'd2,
        OP_ATAN    = 4'd3,
        OP_SINH    = 4'd4,
        OP_COSH    = 4'd5,
        OP_TANH    = 4'd6,
        OP_ATANH   = 4'd7,
        OP_EXP     = 4'd8,
        OP_LN      = 4'd9,
        OP_MULT    = 4'd10,
        OP_DIV     = 4'd11,
        OP_MAG     = 4'd12,
        OP_PHASE   = 4'd13,
        OP_SQRT    = 4'd14,
        OP_DEFAULT = 4'd15
    } op_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_op_dispatcher_if.sv
// Command, calculator and response signals of the dispatcher.
// slave = dispatcher view, master = host/calculator view.
interface cordic_op_dispatcher_if;
    import cordic_op_dispatcher_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [OP_W-1:0]  s_op;
    logic [WIDTH-1:0] s_x;
    logic [WIDTH-1:0] s_y;
    logic [WIDTH-1:0] s_z;
    logic [TAG_W-1:0] s_tag;

    logic             c_enable;
    logic [OP_W-1:0]  c_op;
    logic [WIDTH-1:0] c_x;
    logic [WIDTH-1:0] c_y;
    logic [WIDTH-1:0] c_z;
    logic [WIDTH-1:0] c_result;
    logic             c_done;

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_result;
    logic [TAG_W-1:0] m_tag;
    logic             m_err;
    logic             busy;

    modport slave (
        input  s_valid, s_op, s_x, s_y, s_z, s_tag,
        output s_ready,
        output c_enable, c_op, c_x, c_y, c_z,
        input  c_result, c_done,
        output m_valid, m_result, m_tag, m_err,
        input  m_ready,
        output busy
    );

    modport master (
        output s_valid, s_op, s_x, s_y, s_z, s_tag,
        input  s_ready,
        input  c_enable, c_op, c_x, c_y, c_z,
        output c_result, c_done,
        input  m_valid, m_result, m_tag, m_err,
        output m_ready,
        input  busy
    );

endinterface

// File: rtl/cordic_op_dispatcher_fifo.sv
// Synchronous command FIFO, no bypass; full/empty are registered so a
// pop while full frees the slot only on the following cycle.
module cordic_op_dispatcher_fifo
    import cordic_op_dispatcher_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  cmd_t                              wdata,
    input  logic                              pop,
    output cmd_t                              rdata,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
            full  <= (count_d == CNT_W'(FIFO_DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cordic_op_dispatcher.sv
// Queues CORDIC requests, issues them one at a time to the calculator and
// returns tagged results in order on a valid/ready stream.
module cordic_op_dispatcher
    import cordic_op_dispatcher_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT
) (
    input logic                   clk,
    input logic                   rst_n,
    cordic_op_dispatcher_if.slave bus
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e           state_q;
    state_e           state_d;
    cmd_t             wdata;
    cmd_t             head;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;

    logic             c_enable_d;
    logic [OP_W-1:0]  c_op_d;
    logic [WIDTH-1:0] c_x_d;
    logic [WIDTH-1:0] c_y_d;
    logic [WIDTH-1:0] c_z_d;
    logic             m_valid_d;
    logic [WIDTH-1:0] m_result_d;
    logic [TAG_W-1:0] m_tag_d;
    logic             m_err_d;

    assign wdata = '{op: bus.s_op, x: bus.s_x, y: bus.s_y, z: bus.s_z, tag: bus.s_tag};

    cordic_op_dispatcher_fifo #(
        .FIFO_DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.s_valid),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.s_ready = !full;
    assign bus.busy    = (state_q != ST_IDLE) || (count != '0);

    // Next state plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tmo_d      = tmo_q;
        c_enable_d = 1'b0;
        c_op_d     = bus.c_op;
        c_x_d      = bus.c_x;
        c_y_d      = bus.c_y;
        c_z_d      = bus.c_z;
        m_valid_d  = bus.m_valid;
        m_result_d = bus.m_result;
        m_tag_d    = bus.m_tag;
        m_err_d    = bus.m_err;

        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    m_tag_d = head.tag;
                    if (head.op == OP_DEFAULT) begin
                        m_valid_d  = 1'b1;
                        m_result_d = '0;
                        m_err_d    = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        c_enable_d = 1'b1;
                        c_op_d     = head.op;
                        c_x_d      = head.x;
                        c_y_d      = head.y;
                        c_z_d      = head.z;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the last allowed cycle still counts as success.
                if (bus.c_done) begin
                    m_valid_d  = 1'b1;
                    m_result_d = bus.c_result;
                    m_err_d    = 1'b0;
                    state_d    = ST_RESP;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    m_valid_d  = 1'b1;
                    m_result_d = '0;
                    m_err_d    = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            bus.c_enable <= 1'b0;
            bus.c_op     <= OP_DEFAULT;
            bus.c_x      <= '0;
            bus.c_y      <= '0;
            bus.c_z      <= '0;
            bus.m_valid  <= 1'b0;
            bus.m_result <= '0;
            bus.m_tag    <= '0;
            bus.m_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            bus.c_enable <= c_enable_d;
            bus.c_op     <= c_op_d;
            bus.c_x      <= c_x_d;
            bus.c_y      <= c_y_d;
            bus.c_z      <= c_z_d;
            bus.m_valid  <= m_valid_d;
            bus.m_result <= m_result_d;
            bus.m_tag    <= m_tag_d;
            bus.m_err    <= m_err_d;
        end
    end

endmodule
